// File: rtl/icache_dm_param.sv
// Parametrised direct-mapped, read-only instruction cache with a line-fill state machine.
// Defining ICACHE_STATS_EN adds the stat_hits / stat_misses counter outputs.
module icache_dm_param #(
  parameter int ADDR_W     = 32,
  parameter int LINES      = 16,
  parameter int LINE_WORDS = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_req,
  output logic              rd_wait,
  output logic [31:0]       rd_data,
  input  logic              invalidate,
  output logic              bus_req,
  input  logic              bus_ack,
  output logic [ADDR_W-1:0] bus_addr,
  input  logic [31:0]       bus_data,
  output logic              bus_rd,
  output logic              bus_wr,
  input  logic              bus_ready
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0]       stat_hits,
  output logic [31:0]       stat_misses
`endif
);

  localparam int WIDX    = $clog2(LINE_WORDS);
  localparam int LIDX    = $clog2(LINES);
  localparam int TAG_LSB = LIDX + WIDX + 2;
  localparam int TAG_W   = ADDR_W - TAG_LSB;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    DONE
  } state_e;

  state_e            state_q, state_d;
  logic [LINES-1:0]  valid_q, valid_d;
  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [31:0]       data_q [LINES][LINE_WORDS];
  logic [ADDR_W-1:0] base_q, base_d;
  logic [WIDX-1:0]   fill_pos_q, fill_pos_d;
  logic              discard_q, discard_d;
  logic [ADDR_W-1:0] bus_addr_q;

  logic [WIDX-1:0]   rd_word;
  logic [LIDX-1:0]   rd_idx;
  logic [LIDX-1:0]   fill_idx;
  logic [TAG_W-1:0]  rd_tag;
  logic [TAG_W-1:0]  fill_tag;
  logic              hit;
  logic              beat;
  logic              last_beat;
  logic              unused_byte_bits;

  assign rd_word          = rd_addr[WIDX+1:2];
  assign rd_idx           = rd_addr[TAG_LSB-1:WIDX+2];
  assign rd_tag           = rd_addr[ADDR_W-1:TAG_LSB];
  assign fill_idx         = base_q[TAG_LSB-1:WIDX+2];
  assign fill_tag         = base_q[ADDR_W-1:TAG_LSB];
  assign unused_byte_bits = ^rd_addr[1:0];

  assign hit     = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
  assign rd_wait = rd_req && !hit;
  assign rd_data = data_q[rd_idx][rd_word];

  // Bus outputs derive from the state register so an async reset drops them at once.
  assign bus_req   = (state_q == FILL);
  assign bus_rd    = (state_q == FILL) && bus_ack;
  assign bus_wr    = 1'b0;
  assign bus_addr  = bus_rd ? (base_q + (ADDR_W'(fill_pos_q) << 2)) : bus_addr_q;
  assign beat      = (state_q == FILL) && bus_ack && bus_ready;
  assign last_beat = beat && (fill_pos_q == WIDX'(LINE_WORDS - 1));

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    fill_pos_d = fill_pos_q;
    discard_d  = discard_q;
    valid_d    = valid_q;
    case (state_q)
      IDLE: begin
        // The victim line is dropped at miss time so it never serves half-overwritten data.
        if (rd_wait) begin
          base_d          = {rd_addr[ADDR_W-1:WIDX+2], {(WIDX + 2){1'b0}}};
          fill_pos_d      = '0;
          discard_d       = 1'b0;
          valid_d[rd_idx] = 1'b0;
          state_d         = FILL;
        end
      end
      FILL: begin
        if (invalidate) begin
          discard_d = 1'b1;
        end
        if (beat) begin
          fill_pos_d = fill_pos_q + 1'b1;
          if (last_beat) begin
            valid_d[fill_idx] = !(discard_q || invalidate);
            state_d           = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (invalidate) begin
      valid_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      valid_q    <= '0;
      base_q     <= '0;
      fill_pos_q <= '0;
      discard_q  <= 1'b0;
      bus_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      base_q     <= base_d;
      fill_pos_q <= fill_pos_d;
      discard_q  <= discard_d;
      bus_addr_q <= bus_addr;
    end
  end

  // Storage arrays carry no reset; validity alone decides whether their contents matter.
  always_ff @(posedge clk) begin
    if (beat) begin
      data_q[fill_idx][fill_pos_q] <= bus_data;
      if (last_beat) begin
        tag_q[fill_idx] <= fill_tag;
      end
    end
  end

`ifdef ICACHE_STATS_EN
  logic [31:0] hits_q;
  logic [31:0] misses_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hits_q   <= '0;
      misses_q <= '0;
    end else if (invalidate) begin
      hits_q   <= '0;
      misses_q <= '0;
    end else begin
      if ((state_q == IDLE) && rd_req && hit) begin
        hits_q <= hits_q + 32'd1;
      end
      if ((state_q == IDLE) && rd_wait) begin
        misses_q <= misses_q + 32'd1;
      end
    end
  end

  assign stat_hits   = hits_q;
  assign stat_misses = misses_q;
`endif

endmodule

// File: tb/tb_icache_dm_param.sv
// Self-checking bench for icache_dm_param: a line-level cache model checked every cycle,
// directed scenarios with literal expectations, a random phase and a small-geometry instance.
module tb_icache_dm_param;

  localparam int LINES      = 16;
  localparam int LW         = 16;
  localparam int LINE_BYTES = LW * 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] rd_addr = '0;
  logic        rd_req = 1'b0;
  logic        invalidate = 1'b0;
  logic        bus_ack = 1'b0;
  logic        bus_ready = 1'b0;
  logic        rd_wait, bus_req, bus_rd, bus_wr;
  logic [31:0] rd_data, bus_addr, bus_data;
`ifdef ICACHE_STATS_EN
  logic [31:0] stat_hits, stat_misses;
  logic [31:0] s_stat_hits, s_stat_misses;
`endif

  logic [31:0] sAddr = '0;
  logic        sReq = 1'b0;
  logic        sOne = 1'b1;
  logic        sZero = 1'b0;
  logic        s_rd_wait, s_bus_req, s_bus_rd, s_bus_wr;
  logic [31:0] s_rd_data, s_bus_addr, s_bus_data;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Backing memory: each word's content is a fixed scramble of its word address.
  function automatic logic [31:0] memWord(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    return (w * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  assign bus_data   = bus_ready ? memWord(bus_addr) : 32'hDEAD_BEEF;
  assign s_bus_data = memWord(s_bus_addr);

  icache_dm_param #(.ADDR_W(32), .LINES(LINES), .LINE_WORDS(LW)) dut (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_req(rd_req), .rd_wait(rd_wait),
    .rd_data(rd_data), .invalidate(invalidate), .bus_req(bus_req), .bus_ack(bus_ack),
    .bus_addr(bus_addr), .bus_data(bus_data), .bus_rd(bus_rd), .bus_wr(bus_wr),
    .bus_ready(bus_ready)
`ifdef ICACHE_STATS_EN
    , .stat_hits(stat_hits), .stat_misses(stat_misses)
`endif
  );

  icache_dm_param #(.ADDR_W(32), .LINES(4), .LINE_WORDS(4)) dutSmall (
    .clk(clk), .rst_n(rst_n), .rd_addr(sAddr), .rd_req(sReq), .rd_wait(s_rd_wait),
    .rd_data(s_rd_data), .invalidate(sZero), .bus_req(s_bus_req), .bus_ack(sOne),
    .bus_addr(s_bus_addr), .bus_data(s_bus_data), .bus_rd(s_bus_rd), .bus_wr(s_bus_wr),
    .bus_ready(sOne)
`ifdef ICACHE_STATS_EN
    , .stat_hits(s_stat_hits), .stat_misses(s_stat_misses)
`endif
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%h required=%h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic int idxOf(input logic [31:0] a);
    return int'((a / LINE_BYTES) % LINES);
  endfunction

  function automatic logic [31:0] tagOf(input logic [31:0] a);
    return a / (LINE_BYTES * LINES);
  endfunction

  // Model: which lines hold which tags, plus the progress of the fill in flight (phase 0 idle, 1 filling, 2 done).
  int          mPhase;
  int          mBeats;
  bit          mValid [LINES];
  logic [31:0] mTag [LINES];
  logic [31:0] mBase, mLastAddr, mHits, mMisses;
  bit          mDiscard;
  int          uIdx;
  bit          uHit;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mPhase = 0; mBeats = 0; mDiscard = 0; mBase = '0; mLastAddr = '0; mHits = '0; mMisses = '0;
      for (int i = 0; i < LINES; i++) mValid[i] = 0;
    end else begin
      uIdx = idxOf(rd_addr);
      uHit = mValid[uIdx] && (mTag[uIdx] == tagOf(rd_addr));
      if (mPhase == 1 && bus_ack) mLastAddr = mBase + 32'(mBeats * 4);
      if (mPhase == 0) begin
        if (rd_req && uHit) mHits = mHits + 1;
        if (rd_req && !uHit) begin
          mBase = rd_addr - (rd_addr % LINE_BYTES);
          mBeats = 0; mDiscard = 0; mPhase = 1; mMisses = mMisses + 1;
        end
      end else if (mPhase == 1) begin
        if (invalidate) mDiscard = 1;
        if (bus_ack && bus_ready) begin
          mBeats++;
          if (mBeats == LW) begin
            mTag[idxOf(mBase)] = tagOf(mBase);
            mValid[idxOf(mBase)] = !mDiscard;
            mPhase = 2;
          end
        end
      end else begin
        mPhase = 0;
      end
      if (invalidate) begin
        for (int i = 0; i < LINES; i++) mValid[i] = 0;
        mHits = '0; mMisses = '0;
      end
    end
  end

  int          cIdx;
  bit          cHit;
  logic [31:0] cExpAddr;

  // Lines being refilled are in flux, so lookups on that index are not compared until DONE.
  always @(negedge clk) begin
    if (rst_n) begin
      cIdx = idxOf(rd_addr);
      cHit = mValid[cIdx] && (mTag[cIdx] == tagOf(rd_addr));
      if (!(mPhase == 1 && cIdx == idxOf(mBase))) begin
        checkOutput("rd_wait", {31'd0, rd_wait}, {31'd0, rd_req && !cHit});
        if (rd_req && cHit) checkOutput("rd_data", rd_data, memWord(rd_addr));
      end
      cExpAddr = (mPhase == 1 && bus_ack) ? mBase + 32'(mBeats * 4) : mLastAddr;
      checkOutput("bus_req", {31'd0, bus_req}, {31'd0, mPhase == 1});
      checkOutput("bus_rd", {31'd0, bus_rd}, {31'd0, mPhase == 1 && bus_ack});
      checkOutput("bus_addr", bus_addr, cExpAddr);
      checkOutput("bus_wr", {31'd0, bus_wr}, 32'd0);
`ifdef ICACHE_STATS_EN
      checkOutput("stat_hits", stat_hits, mHits);
      checkOutput("stat_misses", stat_misses, mMisses);
`endif
    end
  end

  int          beatCount = 0;
  logic [31:0] firstAddr, lastAddr;
  int          sBeats = 0;
  logic [31:0] sFirst, sLast;

  always @(negedge clk) begin
    if (rst_n && bus_rd && bus_ready) begin
      if (beatCount == 0) firstAddr = bus_addr;
      lastAddr = bus_addr;
      beatCount++;
    end
    if (rst_n && s_bus_rd) begin
      if (sBeats == 0) sFirst = s_bus_addr;
      sLast = s_bus_addr;
      sBeats++;
    end
  end

  task automatic applyStimulus(input logic [31:0] addr, input logic req);
    rd_addr = addr;
    rd_req  = req;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Returns at the negedge of the DONE cycle (first cycle bus_req is low after a fill).
  task automatic runFill(input int budget);
    bit seenReq;
    seenReq = 0;
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      if (bus_req) seenReq = 1;
      else if (seenReq) return;
    end
    checks++;
    failures++;
    $display("[TB] FAIL fill_timeout actual=no_done required=done_within_%0d_cycles", budget);
  endtask

  task automatic waitBeats(input int target, input int budget);
    for (int n = 0; n < budget && beatCount < target; n++) @(negedge clk);
    checkOutput("beat_reached", beatCount, target);
  endtask

  initial begin
    bit seen;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_bus_req", {31'd0, bus_req}, 32'd0);
    checkOutput("reset_bus_rd", {31'd0, bus_rd}, 32'd0);
    checkOutput("reset_bus_addr", bus_addr, 32'd0);
    checkOutput("reset_rd_wait", {31'd0, rd_wait}, 32'd0);
    nextCycle();
    rst_n = 1'b1;

    // Cold miss with the bus always granting and ready.
    bus_ack = 1; bus_ready = 1; beatCount = 0;
    applyStimulus(32'h0000_1044, 1);
    @(negedge clk);
    checkOutput("cold_rd_wait", {31'd0, rd_wait}, 32'd1);
    checkOutput("cold_req_delayed", {31'd0, bus_req}, 32'd0);
    runFill(100);
    checkOutput("cold_beats", beatCount, 16);
    checkOutput("cold_first_addr", firstAddr, 32'h0000_1040);
    checkOutput("cold_last_addr", lastAddr, 32'h0000_107C);
    checkOutput("cold_done_wait", {31'd0, rd_wait}, 32'd0);
    checkOutput("cold_done_data", rd_data, memWord(32'h0000_1044));
    nextCycle();
    @(negedge clk);
    checkOutput("cold_req_low", {31'd0, bus_req}, 32'd0);

    // Hit elsewhere in the freshly filled line.
    nextCycle();
    applyStimulus(32'h0000_1078, 1);
    @(negedge clk);
    checkOutput("hit_wait", {31'd0, rd_wait}, 32'd0);
    checkOutput("hit_data", rd_data, memWord(32'h0000_1078));
    repeat (3) nextCycle();
    checkOutput("hit_no_bus", beatCount, 16);

    // Conflict on index 1 evicts, then the original line misses again.
    beatCount = 0;
    applyStimulus(32'h0000_1440, 1);
    @(negedge clk);
    checkOutput("conflict_wait", {31'd0, rd_wait}, 32'd1);
    runFill(100);
    checkOutput("conflict_first", firstAddr, 32'h0000_1440);
    nextCycle();
    applyStimulus(32'h0000_1040, 1);
    @(negedge clk);
    checkOutput("evicted_wait", {31'd0, rd_wait}, 32'd1);
    runFill(100);

    // Grant dropped for three cycles, ready on alternate cycles.
    nextCycle();
    beatCount = 0; seen = 0;
    applyStimulus(32'h0000_2008, 1);
    for (int c = 0; c < 300 && !seen; c++) begin
      bus_ack = !(c >= 6 && c < 9);
      bus_ready = c[0];
      @(negedge clk);
      if (c == 7) begin
        checkOutput("stall_bus_rd", {31'd0, bus_rd}, 32'd0);
        checkOutput("stall_bus_req", {31'd0, bus_req}, 32'd1);
      end
      if (c > 1 && !bus_req) seen = 1;
      else nextCycle();
    end
    checkOutput("stall_done", {31'd0, seen}, 32'd1);
    checkOutput("stall_beats", beatCount, 16);
    checkOutput("stall_data", rd_data, memWord(32'h0000_2008));
    nextCycle();
    bus_ack = 1; bus_ready = 1;

    // Invalidate during the fill of 0x1040 at beat 5.
    applyStimulus(32'h0, 0);
    invalidate = 1;
    nextCycle();
    invalidate = 0; beatCount = 0;
    applyStimulus(32'h0000_1044, 1);
    waitBeats(5, 50);
    nextCycle();
    invalidate = 1;
    nextCycle();
    invalidate = 0;
    @(negedge clk);
`ifdef ICACHE_STATS_EN
    checkOutput("inv_stat_hits", stat_hits, 32'd0);
    checkOutput("inv_stat_misses", stat_misses, 32'd0);
`endif
    runFill(100);
    checkOutput("inv_beats", beatCount, 16);
    checkOutput("inv_remiss", {31'd0, rd_wait}, 32'd1);
    runFill(100);
`ifdef ICACHE_STATS_EN
    checkOutput("inv_stat_remiss", stat_misses, 32'd1);
`endif
    checkOutput("inv_refill_hit", {31'd0, rd_wait}, 32'd0);

    // Reset arrives after beat 7 of a fill.
    nextCycle();
    beatCount = 0;
    applyStimulus(32'h0000_3004, 1);
    waitBeats(8, 50);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("rst_bus_req", {31'd0, bus_req}, 32'd0);
    checkOutput("rst_bus_rd", {31'd0, bus_rd}, 32'd0);
    nextCycle();
    rst_n = 1'b1;
    beatCount = 0;
    @(negedge clk);
    checkOutput("rst_remiss", {31'd0, rd_wait}, 32'd1);
    runFill(100);
    checkOutput("rst_beats", beatCount, 16);
    checkOutput("rst_first", firstAddr, 32'h0000_3000);

    // Random traffic over a few tags and indices so hits, conflicts and stalls all occur.
    for (int c = 0; c < 3000; c++) begin
      nextCycle();
      if ($urandom_range(0, 3) == 0)
        rd_addr = $urandom_range(4, 6) * (LINE_BYTES * LINES) + $urandom_range(0, 5) * LINE_BYTES
                + $urandom_range(0, LW - 1) * 4 + $urandom_range(0, 3);
      rd_req = ($urandom_range(0, 3) != 0);
      bus_ack = ($urandom_range(0, 3) != 0);
      bus_ready = ($urandom_range(0, 2) != 0);
      invalidate = ($urandom_range(0, 59) == 0);
    end
    nextCycle();
    applyStimulus(32'h0, 0);
    invalidate = 0; bus_ack = 1; bus_ready = 1;
    repeat (40) nextCycle();

    // Small geometry: 4 lines of 4 words, index in address bits [5:4].
    sAddr = 32'h34; sReq = 1; sBeats = 0; seen = 0;
    @(negedge clk);
    checkOutput("small_miss", {31'd0, s_rd_wait}, 32'd1);
    for (int n = 0; n < 100 && !(seen && !s_bus_req); n++) begin
      @(negedge clk);
      if (s_bus_req) seen = 1;
    end
    checkOutput("small_beats", sBeats, 4);
    checkOutput("small_first", sFirst, 32'h30);
    checkOutput("small_last", sLast, 32'h3C);
    checkOutput("small_done_wait", {31'd0, s_rd_wait}, 32'd0);
    checkOutput("small_done_data", s_rd_data, memWord(32'h34));
    nextCycle();
    sAddr = 32'h3C;
    @(negedge clk);
    checkOutput("small_hit", {31'd0, s_rd_wait}, 32'd0);
    checkOutput("small_hit_data", s_rd_data, memWord(32'h3C));
    nextCycle();
    sAddr = 32'h24;
    @(negedge clk);
    checkOutput("small_idx2_miss", {31'd0, s_rd_wait}, 32'd1);
    nextCycle();
    sAddr = 32'h134;
    @(negedge clk);
    checkOutput("small_tag_miss", {31'd0, s_rd_wait}, 32'd1);
    nextCycle();
    sReq = 0;
    repeat (10) nextCycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
